// File: rtl/ssp_pkg.sv
// Shared definitions for the superscalar core: ALU func/type encodings,
// default widths and the multiplier scheduler state encoding.
package ssp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 5;

    localparam logic [2:0] TYPE_RR_ALU = 3'b000;
    localparam logic [2:0] TYPE_RI_ALU = 3'b001;
    localparam logic [2:0] TYPE_LOAD   = 3'b010;
    localparam logic [2:0] TYPE_STORE  = 3'b011;
    localparam logic [2:0] TYPE_BRANCH = 3'b100;
    localparam logic [2:0] TYPE_JUMP   = 3'b101;

    localparam logic [5:0] FUNC_ADD  = 6'b000000;
    localparam logic [5:0] FUNC_SUB  = 6'b000001;
    localparam logic [5:0] FUNC_MUL  = 6'b000010;
    localparam logic [5:0] FUNC_AND  = 6'b000011;
    localparam logic [5:0] FUNC_OR   = 6'b000100;
    localparam logic [5:0] FUNC_XOR  = 6'b000101;
    localparam logic [5:0] FUNC_SLL  = 6'b000110;
    localparam logic [5:0] FUNC_SRL  = 6'b000111;
    localparam logic [5:0] FUNC_SRA  = 6'b001000;
    localparam logic [5:0] FUNC_SLT  = 6'b001001;
    localparam logic [5:0] FUNC_SLTU = 6'b001010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Decode helper: instructions matching this are steered to the shared multiplier.
    function automatic logic is_mul(input logic [2:0] itype, input logic [5:0] func);
        return (itype == TYPE_RR_ALU) && (func == FUNC_MUL);
    endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Fixed-latency shift-add multiplier: consumes BITS_PER_CYCLE multiplier bits
// per cycle and keeps the low XLEN bits of the product.
module mul_iter_core
    import ssp_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    logic [XLEN-1:0]  a_reg;
    logic [XLEN-1:0]  b_reg;
    logic [XLEN-1:0]  acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             run_reg;

    logic [XLEN-1:0] term [BITS_PER_CYCLE];
    logic [XLEN-1:0] partial;

    // One shifted copy of the multiplicand per multiplier bit in this slice.
    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
            assign term[gi] = b_reg[gi] ? (a_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            partial = partial + term[i];
        end
    end

    assign done    = run_reg && (cnt_reg == LAST_STEP);
    assign product = acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b0;
        end else if (flush) begin
            run_reg <= 1'b0;
        end else if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            acc_reg <= '0;
            cnt_reg <= '0;
            run_reg <= 1'b1;
        end else if (run_reg) begin
            acc_reg <= acc_reg + partial;
            a_reg   <= a_reg << BITS_PER_CYCLE;
            b_reg   <= b_reg >> BITS_PER_CYCLE;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one iterative multiplier between the two
// issue lanes; returns the tagged low half of the product via valid/ready.
module mul_share_sched
    import ssp_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int BITS_PER_CYCLE = 4,
    parameter int TAG_W          = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [XLEN-1:0]  a0,
    input  logic [XLEN-1:0]  b0,
    input  logic [TAG_W-1:0] tag0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [XLEN-1:0]  a1,
    input  logic [XLEN-1:0]  b1,
    input  logic [TAG_W-1:0] tag1,
    output logic             gnt1,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic             res_lane,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    state_t           state_reg;
    state_t           state_next;
    logic             rr_ptr_reg;
    logic             rr_ptr_next;
    logic [TAG_W-1:0] tag_reg;
    logic             lane_reg;

    logic             start;
    logic             core_done;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  product;

    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (!flush) begin
                    // Lane 0 wins when alone or when it holds the round-robin token.
                    if (req0 && (!req1 || !rr_ptr_reg)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    state_next  = CALC;
                    rr_ptr_next = gnt0;
                end
            end
            CALC: begin
                if (core_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    assign start = gnt0 | gnt1;
    assign op_a  = gnt1 ? a1 : a0;
    assign op_b  = gnt1 ? b1 : b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            tag_reg    <= '0;
            lane_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (start) begin
                tag_reg  <= gnt1 ? tag1 : tag0;
                lane_reg <= gnt1;
            end
        end
    end

    mul_iter_core #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .a       (op_a),
        .b       (op_b),
        .done    (core_done),
        .product (product)
    );

    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign res_data  = product;
    assign res_lane  = lane_reg;
    assign res_tag   = tag_reg;

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched: inputs driven and outputs sampled on
// the falling edge, expected results queued at grant time.
module tb_mul_share_sched;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, flush, res_ready;
    logic [XLEN-1:0]  a0, b0, a1, b1;
    logic [TAG_W-1:0] tag0, tag1;
    logic             gnt0, gnt1, res_valid, res_lane, busy;
    logic [XLEN-1:0]  res_data;
    logic [TAG_W-1:0] res_tag;

    typedef struct packed {
        logic             lane;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic proto_err   = 1'b0;

    mul_share_sched #(.XLEN(XLEN), .BITS_PER_CYCLE(4), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .tag0      (tag0),
        .gnt0      (gnt0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .tag1      (tag1),
        .gnt1      (gnt1),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_lane  (res_lane),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Requesters must hold req and operands until granted.
    logic        p_pend0 = 1'b0, p_pend1 = 1'b0;
    logic [68:0] p_op0 = '0, p_op1 = '0;
    always @(posedge clk) begin
        if (rst_n === 1'b1 && p_pend0 && {req0, a0, b0, tag0} !== {1'b1, p_op0}) proto_err <= 1'b1;
        if (rst_n === 1'b1 && p_pend1 && {req1, a1, b1, tag1} !== {1'b1, p_op1}) proto_err <= 1'b1;
        p_pend0 <= (rst_n === 1'b1) && req0 && !gnt0;
        p_pend1 <= (rst_n === 1'b1) && req1 && !gnt1;
        p_op0   <= {a0, b0, tag0};
        p_op1   <= {a1, b1, tag1};
    end

    function automatic exp_t mk(input logic lane, input logic [TAG_W-1:0] tag,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        e.lane = lane;
        e.tag  = tag;
        e.data = a * b;
        return e;
    endfunction

    // Waits (bounded) for res_valid; only counts cycles.
    task automatic wait_valid(input int start, output int n);
        n = start;
        while (res_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 0; req1 = 0; flush = 0; res_ready = 1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; tag0 = '0; tag1 = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({res_valid, busy, res_lane, res_tag, res_data, gnt0, gnt1} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b busy=%b lane=%b tag=%0d data=%h gnt=%b%b, expected all 0",
                     res_valid, busy, res_lane, res_tag, res_data, gnt0, gnt1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        int n; exp_t e;
        req0 = 1; a0 = 7; b0 = 6; tag0 = 3; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_gnt: got gnt0/gnt1=%b%b expected 10", gnt0, gnt1);
        end
        sb.push_back(mk(1'b0, tag0, a0, b0));
        @(negedge clk); req0 = 0;
        wait_valid(1, n);
        vectors++;
        if (n !== 9) begin
            miscompares++;
            $display("FAIL single_latency: got %0d cycles expected 9", n);
        end
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL single_result: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn single lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_valid_drop: got %b expected 0", res_valid);
        end
    endtask

    task automatic test_fairness();
        int n; exp_t e;
        rst_n = 0; sb.delete();
        @(negedge clk); rst_n = 1;
        req0 = 1; a0 = 32'd11; b0 = 32'd13; tag0 = 5'd1;
        req1 = 1; a1 = 32'h0001_0003; b1 = 32'd100; tag1 = 5'd2;
        #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            miscompares++;
            $display("FAIL fair_first: got gnt0/gnt1=%b%b expected 10", gnt0, gnt1);
        end
        sb.push_back(mk(1'b0, tag0, a0, b0));
        @(negedge clk); req0 = 0;
        wait_valid(1, n);
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL fair_res0: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn fair0 lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
        req0 = 1; a0 = 32'hFFFF_0001; b0 = 32'd3; tag0 = 5'd4; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b00) begin
            miscompares++;
            $display("FAIL fair_done_nogrant: got gnt0/gnt1=%b%b expected 00", gnt0, gnt1);
        end
        @(negedge clk); #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b01) begin
            miscompares++;
            $display("FAIL fair_second: got gnt0/gnt1=%b%b expected 01", gnt0, gnt1);
        end
        sb.push_back(mk(1'b1, tag1, a1, b1));
        @(negedge clk); req1 = 0;
        wait_valid(1, n);
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL fair_res1: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn fair1 lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
        req1 = 1; a1 = 32'd9; b1 = 32'd9; tag1 = 5'd5;
        @(negedge clk); #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            miscompares++;
            $display("FAIL fair_third: got gnt0/gnt1=%b%b expected 10", gnt0, gnt1);
        end
        sb.push_back(mk(1'b0, tag0, a0, b0));
        @(negedge clk); req0 = 0;
        wait_valid(1, n);
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL fair_res2: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn fair2 lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
        @(negedge clk); #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b01) begin
            miscompares++;
            $display("FAIL fair_fourth: got gnt0/gnt1=%b%b expected 01", gnt0, gnt1);
        end
        sb.push_back(mk(1'b1, tag1, a1, b1));
        @(negedge clk); req1 = 0;
        wait_valid(1, n);
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL fair_res3: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn fair3 lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
    endtask

    task automatic test_backpressure();
        int n; exp_t e;
        @(negedge clk);
        res_ready = 0;
        req0 = 1; a0 = 32'h0000_1234; b0 = 32'h0000_0101; tag0 = 5'd9; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_gnt0: got gnt0/gnt1=%b%b expected 10", gnt0, gnt1);
        end
        sb.push_back(mk(1'b0, tag0, a0, b0));
        @(negedge clk); req0 = 0;
        req1 = 1; a1 = 32'hCAFE_0005; b1 = 32'd7; tag1 = 5'd10;
        wait_valid(1, n);
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) res_ready = 1;
            #1;
            vectors++;
            if ({res_valid, busy, gnt1, res_lane, res_tag, res_data} !== {3'b110, e.lane, e.tag, e.data}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got valid=%b busy=%b gnt1=%b lane=%b tag=%0d data=%h expected 1 1 0 %b %0d %h",
                         i, res_valid, busy, gnt1, res_lane, res_tag, res_data, e.lane, e.tag, e.data);
            end
        end
        $display("txn bp0 lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
        @(negedge clk); #1;
        vectors++;
        if ({gnt1, res_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_gnt1_after: got gnt1=%b valid=%b expected 1 0", gnt1, res_valid);
        end
        sb.push_back(mk(1'b1, tag1, a1, b1));
        @(negedge clk); req1 = 0;
        wait_valid(1, n);
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL bp_res1: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn bp1 lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
    endtask

    task automatic test_wrap();
        int n; exp_t e;
        logic [XLEN-1:0] ta [6];
        logic [XLEN-1:0] tb [6];
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd2;
        ta[1] = 32'h0001_0000; tb[1] = 32'h0001_0000;
        ta[2] = 32'h0000_0000; tb[2] = 32'hDEAD_BEEF;
        for (int i = 3; i < 6; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req0 = 1; a0 = ta[i]; b0 = tb[i]; tag0 = 5'(16 + i); #1;
            vectors++;
            if (gnt0 !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_gnt%0d: got %b expected 1", i, gnt0);
            end
            sb.push_back(mk(1'b0, tag0, a0, b0));
            @(negedge clk); req0 = 0;
            wait_valid(1, n);
            e = sb.pop_front();
            vectors++;
            if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
                miscompares++;
                $display("FAIL wrap_res%0d: %h*%h got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                         i, ta[i], tb[i], res_lane, res_tag, res_data, e.lane, e.tag, e.data);
            end
            $display("txn wrap%0d %h*%h lane=%0d tag=%0d data=%h", i, ta[i], tb[i], res_lane, res_tag, res_data);
        end
    endtask

    task automatic test_flush();
        int n; exp_t e;
        @(negedge clk);
        req0 = 1; a0 = 32'd1234; b0 = 32'd5678; tag0 = 5'd11; #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_gnt0: got %b expected 1", gnt0);
        end
        @(negedge clk); req0 = 0;
        req1 = 1; a1 = 32'h8000_0003; b1 = 32'd6; tag1 = 5'd12;
        @(negedge clk);
        @(negedge clk); flush = 1; #1;
        vectors++;
        if ({gnt1, res_valid, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL flush_pulse: got gnt1=%b valid=%b busy=%b expected 0 0 1", gnt1, res_valid, busy);
        end
        @(negedge clk); flush = 0;
        vectors++;
        if ({busy, res_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_idle: got busy=%b valid=%b expected 0 0", busy, res_valid);
        end
        #1;
        vectors++;
        if (gnt1 !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_gnt1: got %b expected 1", gnt1);
        end
        sb.push_back(mk(1'b1, tag1, a1, b1));
        @(negedge clk); req1 = 0;
        wait_valid(1, n);
        vectors++;
        if (n !== 9) begin
            miscompares++;
            $display("FAIL flush_latency: got %0d cycles expected 9", n);
        end
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL flush_res: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn flush lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
    endtask

    task automatic test_async_reset();
        int n; exp_t e;
        @(negedge clk);
        req0 = 1; a0 = 32'd77; b0 = 32'd88; tag0 = 5'd13; #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_gnt0: got %b expected 1", gnt0);
        end
        @(negedge clk); req0 = 0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_busy_before: got %b expected 1", busy);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL arst_immediate: got valid=%b busy=%b expected 0 0", res_valid, busy);
        end
        sb.delete();
        @(negedge clk); rst_n = 1;
        req1 = 1; a1 = 32'd123456; b1 = 32'd654321; tag1 = 5'd14; #1;
        vectors++;
        if ({gnt0, gnt1} !== 2'b01) begin
            miscompares++;
            $display("FAIL arst_gnt1: got gnt0/gnt1=%b%b expected 01", gnt0, gnt1);
        end
        sb.push_back(mk(1'b1, tag1, a1, b1));
        @(negedge clk); req1 = 0;
        wait_valid(1, n);
        vectors++;
        if (n !== 9) begin
            miscompares++;
            $display("FAIL arst_latency: got %0d cycles expected 9", n);
        end
        e = sb.pop_front();
        vectors++;
        if ({res_lane, res_tag, res_data} !== {e.lane, e.tag, e.data}) begin
            miscompares++;
            $display("FAIL arst_res: got lane=%b tag=%0d data=%h expected lane=%b tag=%0d data=%h",
                     res_lane, res_tag, res_data, e.lane, e.tag, e.data);
        end
        $display("txn arst lane=%0d tag=%0d data=%h", res_lane, res_tag, res_data);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_flush();
        test_async_reset();
        @(negedge clk);
        vectors++;
        if (proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL protocol_hold: got violation=%b expected 0", proto_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
